// File: rtl/flicky_video_pkg.sv
// Shared raster timing constants for the flicky video path.
// The timing generator and the video stage both size themselves from these.
package flicky_video_pkg;

    localparam int H_TOTAL   = 320;
    localparam int V_TOTAL   = 264;
    localparam int H_VISIBLE = 256;
    localparam int V_VISIBLE = 224;
    localparam int IRQ_LINE  = 224;
    localparam int HS_START  = 280;
    localparam int HS_WIDTH  = 32;
    localparam int VS_START  = 240;
    localparam int VS_WIDTH  = 3;

    function automatic logic [8:0] sext_ofs(input logic [3:0] ofs);
        return {{5{ofs[3]}}, ofs};
    endfunction

endpackage

// File: rtl/flicky_sync_win.sv
// Registered decode of one sync window: level is high while count lies in
// [start, start+WIDTH-1]. Callers feed the next-count so the level is aligned.
module flicky_sync_win #(
    parameter int WIDTH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] count,
    input  logic [8:0] start,
    output logic       level
);

    logic [9:0] stop;

    assign stop = {1'b0, start} + 10'(WIDTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b0;
        end else begin
            level <= ({1'b0, count} >= {1'b0, start}) && ({1'b0, count} < stop);
        end
    end

endmodule

// File: rtl/flicky_hv_timing.sv
// Horizontal/vertical raster counters, blanking and sync decode, frame count
// and the latched vertical-blank interrupt for the flicky video path.
module flicky_hv_timing #(
    parameter int H_TOTAL   = flicky_video_pkg::H_TOTAL,
    parameter int V_TOTAL   = flicky_video_pkg::V_TOTAL,
    parameter int H_VISIBLE = flicky_video_pkg::H_VISIBLE,
    parameter int V_VISIBLE = flicky_video_pkg::V_VISIBLE,
    parameter int IRQ_LINE  = flicky_video_pkg::IRQ_LINE,
    parameter int HS_START  = flicky_video_pkg::HS_START,
    parameter int HS_WIDTH  = flicky_video_pkg::HS_WIDTH,
    parameter int VS_START  = flicky_video_pkg::VS_START,
    parameter int VS_WIDTH  = flicky_video_pkg::VS_WIDTH
) (
    input  logic       VCLK,
    input  logic       RESET_N,
    input  logic [3:0] HOFS,
    input  logic [3:0] VOFS,
    input  logic       IRQ_ACK,
    output logic [8:0] PH,
    output logic [8:0] PV,
    output logic       HBLK,
    output logic       VBLK,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       IRQ,
    output logic [7:0] FRAME
);

    import flicky_video_pkg::*;

    logic       h_wrap;
    logic       frame_wrap;
    logic       irq_set;
    logic [8:0] ph_next;
    logic [8:0] pv_next;
    logic [8:0] hofs_l;
    logic [8:0] vofs_l;
    logic [8:0] hofs_next;
    logic [8:0] vofs_next;
    logic [8:0] hs_start;
    logic [8:0] vs_start;

    // Offsets are swapped in at the frame boundary and the sync decode for
    // the first pixel of the new frame already sees the new values.
    always_comb begin
        h_wrap     = (PH == 9'(H_TOTAL - 1));
        frame_wrap = h_wrap && (PV == 9'(V_TOTAL - 1));
        ph_next    = h_wrap ? 9'd0 : PH + 9'd1;
        pv_next    = PV;
        if (h_wrap) begin
            pv_next = frame_wrap ? 9'd0 : PV + 9'd1;
        end
        hofs_next  = frame_wrap ? sext_ofs(HOFS) : hofs_l;
        vofs_next  = frame_wrap ? sext_ofs(VOFS) : vofs_l;
        hs_start   = 9'(HS_START) + hofs_next;
        vs_start   = 9'(VS_START) + vofs_next;
        irq_set    = (PH == 9'd0) && (PV == 9'(IRQ_LINE));
    end

    always_ff @(posedge VCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            PH     <= '0;
            PV     <= '0;
            hofs_l <= '0;
            vofs_l <= '0;
            HBLK   <= 1'b0;
            VBLK   <= 1'b0;
            IRQ    <= 1'b0;
            FRAME  <= '0;
        end else begin
            PH     <= ph_next;
            PV     <= pv_next;
            hofs_l <= hofs_next;
            vofs_l <= vofs_next;
            HBLK   <= (ph_next >= 9'(H_VISIBLE));
            VBLK   <= (pv_next >= 9'(V_VISIBLE));
            IRQ    <= irq_set | (IRQ & ~IRQ_ACK);
            FRAME  <= FRAME + 8'(frame_wrap);
        end
    end

    flicky_sync_win #(.WIDTH(HS_WIDTH)) u_hsync (
        .clk   (VCLK),
        .rst_n (RESET_N),
        .count (ph_next),
        .start (hs_start),
        .level (HSYNC)
    );

    flicky_sync_win #(.WIDTH(VS_WIDTH)) u_vsync (
        .clk   (VCLK),
        .rst_n (RESET_N),
        .count (pv_next),
        .start (vs_start),
        .level (VSYNC)
    );

endmodule

// File: tb/tb_flicky_hv_timing.sv
// Scoreboard bench for flicky_hv_timing on a shrunken raster so that a full
// 256-frame FRAME rollover fits in a short run.
module tb_flicky_hv_timing;

    localparam int H  = 17;
    localparam int V  = 17;
    localparam int HV = 12;
    localparam int VV = 12;
    localparam int IL = 12;
    localparam int HS = 8;
    localparam int HW = 2;
    localparam int VS = 8;
    localparam int VW = 2;

    logic       VCLK = 1'b0;
    logic       RESET_N;
    logic [3:0] HOFS;
    logic [3:0] VOFS;
    logic       IRQ_ACK;
    logic [8:0] PH;
    logic [8:0] PV;
    logic       HBLK;
    logic       VBLK;
    logic       HSYNC;
    logic       VSYNC;
    logic       IRQ;
    logic [7:0] FRAME;

    flicky_hv_timing #(
        .H_TOTAL(H), .V_TOTAL(V), .H_VISIBLE(HV), .V_VISIBLE(VV), .IRQ_LINE(IL),
        .HS_START(HS), .HS_WIDTH(HW), .VS_START(VS), .VS_WIDTH(VW)
    ) dut (
        .VCLK    (VCLK),
        .RESET_N (RESET_N),
        .HOFS    (HOFS),
        .VOFS    (VOFS),
        .IRQ_ACK (IRQ_ACK),
        .PH      (PH),
        .PV      (PV),
        .HBLK    (HBLK),
        .VBLK    (VBLK),
        .HSYNC   (HSYNC),
        .VSYNC   (VSYNC),
        .IRQ     (IRQ),
        .FRAME   (FRAME)
    );

    always #5 VCLK = ~VCLK;

    typedef struct {
        int ph;
        int pv;
        int hblk;
        int vblk;
        int hs;
        int vs;
        int irq;
        int frame;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference state: cycles since reset release plus per-frame offsets.
    int   t    = 0;
    int   mh   = 0;
    int   mv   = 0;
    int   mirq = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Advance the reference by one pixel clock using the inputs seen at the edge.
    task automatic step();
        exp_t e;
        int   ph0;
        int   pv0;
        ph0 = t % H;
        pv0 = (t / H) % V;
        if (ph0 == H - 1 && pv0 == V - 1) begin
            mh = $signed(HOFS);
            mv = $signed(VOFS);
        end
        mirq = ((ph0 == 0 && pv0 == IL) || (mirq != 0 && IRQ_ACK == 1'b0)) ? 1 : 0;
        t++;
        e.ph    = t % H;
        e.pv    = (t / H) % V;
        e.hblk  = (e.ph >= HV) ? 1 : 0;
        e.vblk  = (e.pv >= VV) ? 1 : 0;
        e.hs    = (e.ph >= HS + mh && e.ph <= HS + mh + HW - 1) ? 1 : 0;
        e.vs    = (e.pv >= VS + mv && e.pv <= VS + mv + VW - 1) ? 1 : 0;
        e.irq   = mirq;
        e.frame = (t / (H * V)) % 256;
        q.push_back(e);
    endtask

    task automatic run(int n, bit rnd_ofs);
        for (int i = 0; i < n; i++) begin
            @(posedge VCLK);
            step();
            #1;
            if (rnd_ofs && $urandom_range(0, 49) == 0) HOFS = 4'($urandom_range(0, 15));
            if (rnd_ofs && $urandom_range(0, 49) == 0) VOFS = 4'($urandom_range(0, 15));
            if (t % H == 0 && (t / H) % V == IL)
                IRQ_ACK = 1'($urandom_range(0, 1));
            else
                IRQ_ACK = ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0;
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_ph",    int'(PH),    0);
        chk("rst_pv",    int'(PV),    0);
        chk("rst_hblk",  int'(HBLK),  0);
        chk("rst_vblk",  int'(VBLK),  0);
        chk("rst_hsync", int'(HSYNC), 0);
        chk("rst_vsync", int'(VSYNC), 0);
        chk("rst_irq",   int'(IRQ),   0);
        chk("rst_frame", int'(FRAME), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge VCLK);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ph",    int'(PH),    e.ph);
                chk("pv",    int'(PV),    e.pv);
                chk("hblk",  int'(HBLK),  e.hblk);
                chk("vblk",  int'(VBLK),  e.vblk);
                chk("hsync", int'(HSYNC), e.hs);
                chk("vsync", int'(VSYNC), e.vs);
                chk("irq",   int'(IRQ),   e.irq);
                chk("frame", int'(FRAME), e.frame);
            end
        end
    end

    initial begin : stimulus
        RESET_N = 1'b0;
        HOFS    = 4'd0;
        VOFS    = 4'd0;
        IRQ_ACK = 1'b0;
        #22;
        check_reset_outputs();
        RESET_N = 1'b1;

        // Extreme offsets applied mid-frame only take effect from frame 1.
        run(100, 1'b0);
        HOFS = 4'b1000;
        VOFS = 4'd7;
        run(H * V, 1'b0);

        // Move to line 6, pixel 8, then drop reset between clock edges.
        run((H * V + 6 * H + 8) - t, 1'b1);
        @(negedge VCLK);
        #2;
        RESET_N = 1'b0;
        #1;
        check_reset_outputs();
        #25;
        check_reset_outputs();
        t    = 0;
        mh   = 0;
        mv   = 0;
        mirq = 0;
        RESET_N = 1'b1;

        // 256 full frames plus a few clocks: FRAME must roll over to 0.
        run(256 * H * V + 5, 1'b1);
        @(negedge VCLK);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
